pool_stream: RTL and testbench

- Parametrised KxK pooling engine for row-streamed feature maps.
- Each input beat carries one row slice of R pixels. K consecutive accepted beats form one window row-set.
- Emits one beat of R/K pooled pixels per K input beats. Supports max or average mode, and unsigned or signed pixels.
- Sits between the convolution output stream and the next layer, with valid/ready on both sides. Full throughput: no bubble between windows.

---
 rtl/pool_pkg.sv | 21 ++
 rtl/pool_lane.sv | 72 +++++++
 rtl/pool_stream.sv | 99 +++++++++
 tb/tb_pool_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared mode type and width helpers for the KxK pooling stream engine.
package pool_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_t;

  // Ceiling log2; K is a power of two so this is exact.
  function automatic int log2k(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < k) r = i + 1;
    end
    return r;
  endfunction

  // A KxK sum of W-bit pixels needs 2*log2(K) extra bits to never overflow.
  function automatic int acc_w(input int w, input int k);
    return w + 2 * log2k(k);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One output lane: reduces K adjacent pixels per beat and accumulates across
// the K beats of a window, producing the pooled pixel for the closing beat.
module pool_lane
  import pool_pkg::*;
#(
  parameter int W      = 8,
  parameter int K      = 2,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [K-1:0][W-1:0] px_i,
  input  logic                start_i,
  input  logic                accept_i,
  input  pool_mode_t          mode_i,
  output logic [W-1:0]        res_o
);

  localparam int AW = acc_w(W, K);
  localparam int SH = 2 * log2k(K);

  logic        [AW-1:0] acc_q;
  logic        [AW-1:0] acc_d;
  logic        [AW-1:0] red;
  logic signed [AW-1:0] acc_s;
  logic        [AW-1:0] avg;

  function automatic logic [AW-1:0] ext(input logic [W-1:0] p);
    if (SIGNED != 0) return {{(AW-W){p[W-1]}}, p};
    return {{(AW-W){1'b0}}, p};
  endfunction

  function automatic logic gt(input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Column reduction of this beat's K pixels.
  always_comb begin
    red = ext(px_i[0]);
    for (int i = 1; i < K; i++) begin
      if (mode_i == POOL_MAX) begin
        if (gt(ext(px_i[i]), red)) red = ext(px_i[i]);
      end else begin
        red = red + ext(px_i[i]);
      end
    end
  end

  always_comb begin
    acc_d = red;
    if (!start_i) begin
      if (mode_i == POOL_MAX) acc_d = gt(red, acc_q) ? red : acc_q;
      else                    acc_d = acc_q + red;
    end
  end

  // Arithmetic shift for signed pixels gives floor division of the sum.
  always_comb begin
    acc_s = acc_d;
    if (SIGNED != 0) avg = acc_s >>> SH;
    else             avg = acc_d >> SH;
  end

  assign res_o = (mode_i == POOL_MAX) ? W'(acc_d) : W'(avg);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         acc_q <= '0;
    else if (accept_i) acc_q <= acc_d;
  end

endmodule

// File: rtl/pool_stream.sv
// KxK pooling over a row-streamed feature map: K input beats of R pixels
// produce one output beat of R/K pooled pixels, with valid/ready on both sides.
module pool_stream
  import pool_pkg::*;
#(
  parameter int R      = 8,
  parameter int W      = 8,
  parameter int K      = 2,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  pool_mode_t            mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [R-1:0][W-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [R/K-1:0][W-1:0] m_data
);

  localparam int N  = R / K;
  localparam int CW = log2k(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0]       row_cnt_q, row_cnt_d;
  pool_mode_t          mode_q, mode_d, mode_eff;
  logic                m_valid_q, m_valid_d;
  logic [N-1:0][W-1:0] m_data_q, m_data_d;
  logic [N-1:0][W-1:0] res;
  logic                start, closing, accept;

  // Handshake: a beat transfers on a rising edge where valid && ready.
  // Only the closing beat can stall, and only while a previous result is
  // still held and not being drained in this same cycle.
  assign start   = (row_cnt_q == '0);
  assign closing = (row_cnt_q == LAST);
  assign s_ready = !closing || !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // Mode is latched at window start but must already steer the first beat.
  always_comb begin
    mode_eff = mode_q;
    if (start) mode_eff = mode;
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    pool_lane #(
      .W      (W),
      .K      (K),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .px_i     (s_data[K*j +: K]),
      .start_i  (start),
      .accept_i (accept),
      .mode_i   (mode_eff),
      .res_o    (res[j])
    );
  end

  always_comb begin
    row_cnt_d = row_cnt_q;
    mode_d    = mode_q;
    if (accept) begin
      row_cnt_d = closing ? '0 : row_cnt_q + 1'b1;
      if (start) mode_d = mode;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (m_ready) m_valid_d = 1'b0;
    if (accept && closing) begin
      m_valid_d = 1'b1;
      m_data_d  = res;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt_q <= '0;
      mode_q    <= POOL_MAX;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: three configurations (unsigned K=2, unsigned K=4,
// signed K=2, all R=4 W=8) under directed and randomized windows.
module tb_pool_stream;
  import pool_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic            sv[3];
  logic            mr[3];
  pool_mode_t      mo[3];
  logic [3:0][7:0] sd[3];

  logic            srdy_a, srdy_b, srdy_c;
  logic            mv_a, mv_b, mv_c;
  logic [1:0][7:0] md_a, md_c;
  logic [0:0][7:0] md_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  pool_stream #(.R(4), .W(8), .K(2), .SIGNED(0)) u_dut_a (
    .clk(clk), .rstn(rstn), .mode(mo[0]), .s_valid(sv[0]), .s_ready(srdy_a),
    .s_data(sd[0]), .m_valid(mv_a), .m_ready(mr[0]), .m_data(md_a));

  pool_stream #(.R(4), .W(8), .K(4), .SIGNED(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .mode(mo[1]), .s_valid(sv[1]), .s_ready(srdy_b),
    .s_data(sd[1]), .m_valid(mv_b), .m_ready(mr[1]), .m_data(md_b));

  pool_stream #(.R(4), .W(8), .K(2), .SIGNED(1)) u_dut_c (
    .clk(clk), .rstn(rstn), .mode(mo[2]), .s_valid(sv[2]), .s_ready(srdy_c),
    .s_data(sd[2]), .m_valid(mv_c), .m_ready(mr[2]), .m_data(md_c));

  function automatic int kof(input int u);
    return (u == 1) ? 4 : 2;
  endfunction

  function automatic logic get_srdy(input int u);
    case (u)
      0:       return srdy_a;
      1:       return srdy_b;
      default: return srdy_c;
    endcase
  endfunction

  function automatic logic get_mv(input int u);
    case (u)
      0:       return mv_a;
      1:       return mv_b;
      default: return mv_c;
    endcase
  endfunction

  function automatic logic [15:0] get_md(input int u);
    case (u)
      0:       return md_a;
      1:       return {8'h00, md_b};
      default: return md_c;
    endcase
  endfunction

  function automatic logic [31:0] px4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference: gather each lane's KxK block, take max or floor(mean).
  function automatic logic [15:0] model(input int u, input logic [31:0] beats[$], input bit avg);
    int k, n, v, sum, best, q;
    logic [7:0]  p;
    logic [31:0] row;
    logic [15:0] r;
    k = kof(u);
    n = 4 / k;
    r = '0;
    for (int j = 0; j < n; j++) begin
      sum  = 0;
      best = 0;
      for (int b = 0; b < k; b++) begin
        row = beats[b];
        for (int c = 0; c < k; c++) begin
          p = row[8*(k*j+c) +: 8];
          if (u == 2) v = int'($signed(p));
          else        v = int'(p);
          sum += v;
          if ((b == 0 && c == 0) || v > best) best = v;
        end
      end
      if (avg) begin
        q = sum / (k * k);
        if ((sum % (k * k)) != 0 && sum < 0) q = q - 1;
      end else begin
        q = best;
      end
      r[8*j +: 8] = q[7:0];
    end
    return r;
  endfunction

  // Drives one beat from a negedge and returns at the negedge after it is accepted.
  task automatic send_beat(input int u, input logic [31:0] d, input pool_mode_t m);
    int   n;
    logic ok;
    n     = 0;
    sv[u] = 1'b1;
    sd[u] = d;
    mo[u] = m;
    forever begin
      #1 ok = get_srdy(u);
      @(negedge clk);
      if (ok) break;
      n++;
      if (n > 200) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout[%0d]: s_ready stayed 0 for %0d cycles, required 1", u, n);
        break;
      end
    end
    sv[u] = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_vec++; if (get_mv(u) !== 1'b0) begin n_err++; $display("FAIL reset_m_valid[%0d]: got %b expected 0", u, get_mv(u)); end
      n_vec++; if (get_md(u) !== 16'h0) begin n_err++; $display("FAIL reset_m_data[%0d]: got %h expected 0", u, get_md(u)); end
      n_vec++; if (get_srdy(u) !== 1'b1) begin n_err++; $display("FAIL reset_s_ready[%0d]: got %b expected 1", u, get_srdy(u)); end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    mr[0] = 1'b1;
    send_beat(0, px4(1, 5, 3, 2), POOL_MAX);
    n_vec++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL max_early_valid: got %b expected 0", mv_a); end
    send_beat(0, px4(4, 0, 7, 9), POOL_MAX);
    n_vec++; if (mv_a !== 1'b1) begin n_err++; $display("FAIL max_valid: got %b expected 1", mv_a); end
    n_vec++; if (md_a !== 16'h0905) begin n_err++; $display("FAIL max_data: got %h expected 0905", md_a); end
    @(negedge clk);
    n_vec++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL max_drain: got %b expected 0", mv_a); end
  endtask

  task automatic test_avg();
    send_beat(0, px4(1, 2, 3, 4), POOL_AVG);
    send_beat(0, px4(5, 6, 7, 8), POOL_AVG);
    n_vec++; if (md_a !== 16'h0503 || mv_a !== 1'b1) begin n_err++; $display("FAIL avg_k2: got %h/%b expected 0503/1", md_a, mv_a); end
    @(negedge clk);
    for (int b = 0; b < 4; b++) send_beat(1, px4(255, 255, 255, 255), POOL_AVG);
    n_vec++; if (get_md(1) !== 16'h00ff || mv_b !== 1'b1) begin n_err++; $display("FAIL avg_k4_full: got %h/%b expected 00ff/1", get_md(1), mv_b); end
    @(negedge clk);
    send_beat(2, px4(-1, -2, 0, 0), POOL_AVG);
    send_beat(2, px4(-3, -4, 0, 0), POOL_AVG);
    n_vec++; if (md_c !== 16'h00fd || mv_c !== 1'b1) begin n_err++; $display("FAIL avg_signed: got %h/%b expected 00fd/1", md_c, mv_c); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    mr[0] = 1'b0;
    send_beat(0, px4(1, 5, 3, 2), POOL_MAX);
    send_beat(0, px4(4, 0, 7, 9), POOL_MAX);
    n_vec++; if (md_a !== 16'h0905 || mv_a !== 1'b1) begin n_err++; $display("FAIL bp_first: got %h/%b expected 0905/1", md_a, mv_a); end
    send_beat(0, px4(10, 20, 30, 40), POOL_MAX);
    n_vec++; if (md_a !== 16'h0905 || mv_a !== 1'b1) begin n_err++; $display("FAIL bp_open_hold: got %h/%b expected 0905/1", md_a, mv_a); end
    sv[0] = 1'b1;
    sd[0] = px4(50, 1, 2, 60);
    mo[0] = POOL_AVG;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (srdy_a !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %b expected 0", srdy_a); end
      n_vec++; if (md_a !== 16'h0905 || mv_a !== 1'b1) begin n_err++; $display("FAIL bp_stall_hold: got %h/%b expected 0905/1", md_a, mv_a); end
      @(negedge clk);
    end
    mr[0] = 1'b1;
    #1;
    n_vec++; if (srdy_a !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", srdy_a); end
    @(negedge clk);
    sv[0] = 1'b0;
    n_vec++; if (md_a !== 16'h3c32 || mv_a !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h/%b expected 3c32/1", md_a, mv_a); end
    @(negedge clk);
    n_vec++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", mv_a); end
  endtask

  task automatic test_reset_mid();
    mr[0] = 1'b0;
    send_beat(0, px4(1, 5, 3, 2), POOL_MAX);
    send_beat(0, px4(4, 0, 7, 9), POOL_MAX);
    send_beat(0, px4(9, 9, 9, 9), POOL_MAX);
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (mv_a !== 1'b0 || md_a !== 16'h0) begin n_err++; $display("FAIL rst_async: got %h/%b expected 0000/0", md_a, mv_a); end
    @(negedge clk);
    rstn  = 1'b1;
    mr[0] = 1'b1;
    send_beat(0, px4(1, 1, 1, 1), POOL_MAX);
    n_vec++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL rst_fresh_window: got %b expected 0", mv_a); end
    send_beat(0, px4(2, 2, 2, 2), POOL_MAX);
    n_vec++; if (md_a !== 16'h0202 || mv_a !== 1'b1) begin n_err++; $display("FAIL rst_result: got %h/%b expected 0202/1", md_a, mv_a); end
    @(negedge clk);
  endtask

  task automatic test_mode_change();
    send_beat(0, px4(1, 5, 3, 2), POOL_MAX);
    send_beat(0, px4(4, 0, 7, 9), POOL_AVG);
    n_vec++; if (md_a !== 16'h0905) begin n_err++; $display("FAIL mode_max_kept: got %h expected 0905", md_a); end
    send_beat(0, px4(1, 2, 3, 4), POOL_AVG);
    send_beat(0, px4(5, 6, 7, 8), POOL_MAX);
    n_vec++; if (md_a !== 16'h0503) begin n_err++; $display("FAIL mode_avg_kept: got %h expected 0503", md_a); end
    @(negedge clk);
  endtask

  // Random windows with idle gaps and random downstream stalls.
  task automatic test_random(input int u, input int nwin);
    logic [31:0] beats[$];
    pool_mode_t  m;
    int          k, got, cyc;
    logic [15:0] e;
    got = 0;
    cyc = 0;
    k   = kof(u);
    exp_q.delete();
    fork
      begin : drv
        for (int w = 0; w < nwin; w++) begin
          m = pool_mode_t'($urandom_range(0, 1));
          beats.delete();
          for (int b = 0; b < k; b++) beats.push_back($urandom);
          exp_q.push_back(model(u, beats, m == POOL_AVG));
          for (int b = 0; b < k; b++) begin
            send_beat(u, beats[b], (b == 0) ? m : pool_mode_t'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
          end
        end
      end
      begin : mon
        while (got < nwin && cyc < 5000) begin
          mr[u] = ($urandom_range(0, 3) != 0);
          #1;
          if (get_mv(u) && mr[u]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL rand_unexpected[%0d]: got %h with no result pending", u, get_md(u));
            end else begin
              e = exp_q.pop_front();
              if (get_md(u) !== e) begin
                n_err++;
                $display("FAIL rand_data[%0d] #%0d: got %h expected %h", u, got, get_md(u), e);
              end
            end
            got++;
          end
          @(negedge clk);
          cyc++;
        end
        if (got < nwin) begin
          n_vec++; n_err++;
          $display("FAIL rand_timeout[%0d]: got %0d results expected %0d", u, got, nwin);
        end
        mr[u] = 1'b1;
      end
    join
    @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      sv[u] = 1'b0;
      mr[u] = 1'b1;
      mo[u] = POOL_MAX;
      sd[u] = '0;
    end
    @(negedge clk);
    test_reset();
    test_max();
    test_avg();
    test_backpressure();
    test_reset_mid();
    test_mode_change();
    test_random(0, 40);
    test_random(1, 30);
    test_random(2, 40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
